// File: rtl/median_ctrl_pkg.sv
// rtl/median_ctrl_pkg.sv - shared constants and state encoding for the running-median controller
package median_ctrl_pkg;
  localparam int DATA_LENGTH_DEF = 16;
  localparam int WINDOW_DEF      = 20;
  localparam int CNT_W_DEF       = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PH0  = 2'd1;
  localparam logic [1:0] ST_PH1  = 2'd2;
  localparam logic [1:0] ST_CAP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PH0  = ST_PH0,
    S_PH1  = ST_PH1,
    S_CAP  = ST_CAP
  } ctrl_state_e;
endpackage

// File: rtl/median_out_reg.sv
// rtl/median_out_reg.sv - averages the two middle cells into a held valid/ready median register
module median_out_reg import median_ctrl_pkg::*; #(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [DATA_LENGTH-1:0] load_lo,
  input  logic [DATA_LENGTH-1:0] load_hi,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_LENGTH-1:0] median
);
  logic [DATA_LENGTH:0]   sum;
  logic                   valid_d, valid_q;
  logic [DATA_LENGTH-1:0] median_d, median_q;

  // One extra bit keeps the carry so the average of two max values stays exact.
  assign sum = {1'b0, load_lo} + {1'b0, load_hi};

  always_comb begin
    valid_d  = valid_q;
    median_d = median_q;
    if (load) begin
      valid_d  = 1'b1;
      median_d = DATA_LENGTH'(sum >> 1);
    end else if (valid_q && out_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      valid_q  <= 1'b0;
      median_q <= '0;
    end else begin
      valid_q  <= valid_d;
      median_q <= median_d;
    end
  end

  assign out_valid = valid_q;
  assign median    = median_q;
endmodule

// File: rtl/median_filter_ctrl.sv
// rtl/median_filter_ctrl.sv - sequences insert/delete phases of the systolic median array and its FIFO
module median_filter_ctrl import median_ctrl_pkg::*; #(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_data,
  output logic [DATA_LENGTH-1:0] arr_x,
  output logic                   arr_flag,
  output logic                   arr_en,
  output logic                   arr_del_en,
  output logic                   arr_clr,
  output logic                   fifo_push,
  output logic                   fifo_pop,
  input  logic [DATA_LENGTH-1:0] mid_lo,
  input  logic [DATA_LENGTH-1:0] mid_hi,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] median
);
  ctrl_state_e            state_d, state_q;
  logic [CNT_W-1:0]       count_d, count_q, count_next;
  logic [DATA_LENGTH-1:0] arr_x_d, arr_x_q;
  logic                   arr_en_d, arr_en_q;
  logic                   arr_flag_d, arr_flag_q;
  logic                   arr_del_en_d, arr_del_en_q;
  logic                   fifo_push_d, fifo_push_q;
  logic                   fifo_pop_d, fifo_pop_q;
  logic                   arr_clr_d, arr_clr_q;
  logic                   clr_hold_q;
  logic                   full, cap_load;

  assign full       = (count_q == CNT_W'(WINDOW));
  assign count_next = full ? count_q : count_q + CNT_W'(1);
  assign in_ready   = (state_q == S_IDLE) && !arr_clr_q && (!out_valid || out_ready);

  // Outputs are registered, so each phase's strobes are set on the transition into it.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    arr_x_d      = arr_x_q;
    arr_en_d     = 1'b0;
    arr_flag_d   = 1'b0;
    arr_del_en_d = 1'b0;
    fifo_push_d  = 1'b0;
    fifo_pop_d   = 1'b0;
    arr_clr_d    = clr_hold_q;
    cap_load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          arr_x_d     = in_data;
          state_d     = S_PH0;
          arr_en_d    = 1'b1;
          fifo_push_d = 1'b1;
          fifo_pop_d  = full;
        end
      end
      S_PH0: begin
        state_d      = S_PH1;
        arr_en_d     = 1'b1;
        arr_flag_d   = 1'b1;
        arr_del_en_d = full;
      end
      S_PH1: state_d = S_CAP;
      S_CAP: begin
        count_d  = count_next;
        cap_load = (count_next == CNT_W'(WINDOW));
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clr_hold_q stretches arr_clr one cycle past reset/clear release.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      arr_x_q      <= '0;
      arr_en_q     <= 1'b0;
      arr_flag_q   <= 1'b0;
      arr_del_en_q <= 1'b0;
      fifo_push_q  <= 1'b0;
      fifo_pop_q   <= 1'b0;
      arr_clr_q    <= 1'b1;
      clr_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      arr_x_q      <= arr_x_d;
      arr_en_q     <= arr_en_d;
      arr_flag_q   <= arr_flag_d;
      arr_del_en_q <= arr_del_en_d;
      fifo_push_q  <= fifo_push_d;
      fifo_pop_q   <= fifo_pop_d;
      arr_clr_q    <= arr_clr_d;
      clr_hold_q   <= 1'b0;
    end
  end

  assign arr_x      = arr_x_q;
  assign arr_en     = arr_en_q;
  assign arr_flag   = arr_flag_q;
  assign arr_del_en = arr_del_en_q;
  assign fifo_push  = fifo_push_q;
  assign fifo_pop   = fifo_pop_q;
  assign arr_clr    = arr_clr_q;

  median_out_reg #(
    .DATA_LENGTH (DATA_LENGTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (cap_load),
    .load_lo   (mid_lo),
    .load_hi   (mid_hi),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .median    (median)
  );
endmodule

// File: tb/tb_median_filter_ctrl.sv
// tb/tb_median_filter_ctrl.sv - self-checking bench for median_filter_ctrl with a behavioural array/FIFO model
module tb_median_filter_ctrl;
  localparam int WIN = 20;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, arr_x, mid_lo, mid_hi, median;
  logic        arr_flag, arr_en, arr_del_en, arr_clr, fifo_push, fifo_pop;

  int passed = 0;
  int total  = 0;

  logic [15:0] sent[$];
  logic [15:0] mdl_arr[$];
  logic [15:0] mdl_fifo[$];
  logic [15:0] mdl_tmp[$];
  logic [15:0] pend_x, del_x, mdl_lo, mdl_hi, ovr_lo, ovr_hi, held;
  logic        has_del, found, ovr;

  median_filter_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_x(arr_x), .arr_flag(arr_flag), .arr_en(arr_en), .arr_del_en(arr_del_en),
    .arr_clr(arr_clr), .fifo_push(fifo_push), .fifo_pop(fifo_pop),
    .mid_lo(mid_lo), .mid_hi(mid_hi),
    .out_valid(out_valid), .out_ready(out_ready), .median(median)
  );

  always #5 clk = ~clk;

  assign mid_lo = ovr ? ovr_lo : mdl_lo;
  assign mid_hi = ovr ? ovr_hi : mdl_hi;

  // Array stand-in: a multiset of the current window plus an old-data FIFO.
  always @(posedge clk) begin
    if (arr_clr === 1'b1) begin
      mdl_arr.delete();
      mdl_fifo.delete();
      has_del = 1'b0;
    end else begin
      if (fifo_pop === 1'b1 && mdl_fifo.size() > 0) begin
        del_x   = mdl_fifo.pop_front();
        has_del = 1'b1;
      end
      if (fifo_push === 1'b1) mdl_fifo.push_back(arr_x);
      if (arr_en === 1'b1 && arr_flag === 1'b0) pend_x = arr_x;
      if (arr_en === 1'b1 && arr_flag === 1'b1) begin
        if (arr_del_en === 1'b1 && has_del) begin
          found = 1'b0;
          for (int i = 0; i < mdl_arr.size(); i++) begin
            if (!found && mdl_arr[i] == del_x) begin
              mdl_arr.delete(i);
              found = 1'b1;
            end
          end
          has_del = 1'b0;
        end
        mdl_arr.push_back(pend_x);
      end
    end
    mdl_tmp = mdl_arr;
    mdl_tmp.sort();
    mdl_lo = (mdl_tmp.size() > WIN / 2) ? mdl_tmp[WIN/2-1] : 16'h0;
    mdl_hi = (mdl_tmp.size() > WIN / 2) ? mdl_tmp[WIN/2]   : 16'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_median();
    logic [15:0] t[$];
    t = sent;
    t.sort();
    return (int'(t[WIN/2-1]) + int'(t[WIN/2])) >> 1;
  endfunction

  task automatic send(input logic [15:0] v, output bit acc);
    int n = 0;
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_sample(input logic [15:0] v, input int exp_ovr);
    bit acc;
    bit was_full;
    int em;
    was_full = (sent.size() == WIN);
    sent.push_back(v);
    if (sent.size() > WIN) void'(sent.pop_front());
    send(v, acc);
    check("accept", 32'(acc), 1);
    check("ph0_push", 32'(fifo_push), 1);
    check("ph0_pop", 32'(fifo_pop), 32'(was_full));
    check("ph0_en", 32'({arr_en, arr_flag}), 32'b10);
    check("ph0_arr_x", 32'(arr_x), 32'(v));
    @(posedge clk); #1;
    check("ph1_en", 32'({arr_en, arr_flag}), 32'b11);
    check("ph1_del_en", 32'(arr_del_en), 32'(was_full));
    @(posedge clk); #1;
    check("cap_no_valid", 32'(out_valid), 0);
    check("cap_arr_x", 32'(arr_x), 32'(v));
    @(posedge clk); #1;
    check("out_valid", 32'(out_valid), 32'(sent.size() == WIN));
    if (sent.size() == WIN) begin
      em = (exp_ovr >= 0) ? exp_ovr : exp_median();
      held = 16'(em);
      check("median", 32'(median), 32'(em));
      if (out_ready) begin
        @(posedge clk); #1;
        check("handshake_drop", 32'(out_valid), 0);
      end
    end
  endtask

  initial begin
    bit acc;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; ovr = 1'b0; ovr_lo = '0; ovr_hi = '0;
    mdl_lo = '0; mdl_hi = '0; has_del = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({arr_x, arr_flag, arr_en, arr_del_en, fifo_push, fifo_pop, out_valid}), 0);
    check("rst_median", 32'(median), 0);
    check("rst_arr_clr", 32'(arr_clr), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rel_arr_clr", 32'(arr_clr), 1);
    check("rel_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    check("rel2_arr_clr", 32'(arr_clr), 0);
    check("rel2_in_ready", 32'(in_ready), 1);

    for (int i = 1; i <= WIN; i++) do_sample(16'(i), -1);
    check("fill_median_10", 32'(held), 10);
    do_sample(16'd100, -1);
    check("slide_median_11", 32'(held), 11);

    for (int i = 0; i < 12; i++) do_sample(16'($urandom_range(0, 65535)), -1);

    ovr = 1'b1; ovr_lo = 16'hFFFF; ovr_hi = 16'hFFFF;
    do_sample(16'($urandom_range(0, 65535)), 'hFFFF);
    ovr_hi = 16'hFFFE;
    do_sample(16'($urandom_range(0, 65535)), 'hFFFE);
    ovr = 1'b0;

    out_ready = 1'b0;
    do_sample(16'($urandom_range(0, 65535)), -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_median", 32'(median), 32'(held));
      check("bp_idle", 32'({arr_en, fifo_push}), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_handshake", 32'(out_valid), 0);

    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    sent.delete();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 14; i++) do_sample(16'($urandom_range(0, 65535)), -1);
    send(16'h1234, acc);
    check("s15_accept", 32'(acc), 1);
    @(posedge clk); #1;
    check("s15_ph1", 32'({arr_en, arr_flag}), 32'b11);
    @(negedge clk) clear = 1'b1;
    @(posedge clk); #1;
    check("clr_arr_clr", 32'(arr_clr), 1);
    check("clr_idle", 32'({arr_en, arr_flag, arr_del_en, fifo_push, fifo_pop}), 0);
    check("clr_no_valid", 32'(out_valid), 0);
    check("clr_in_ready", 32'(in_ready), 0);
    @(negedge clk) clear = 1'b0;
    @(posedge clk); #1;
    check("clr_rel_arr_clr", 32'(arr_clr), 1);
    check("clr_rel_no_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("clr_rel2_arr_clr", 32'(arr_clr), 0);
    check("clr_rel2_in_ready", 32'(in_ready), 1);
    sent.delete();
    for (int i = 0; i < WIN; i++) do_sample(16'($urandom_range(0, 65535)), -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
